register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
// - Parametrised multi-entry register file: DEPTH words of WIDTH bits, one write port, two read ports.
// - Byte-lane write strobes; register 0 can be hard-wired to zero.
// - Generalises the single 8-bit write-enabled register to a general-purpose register bank.
// - Used as the operand store for the datapath and CPU blocks on Basys3 designs.
// PARAMETERS
// - WIDTH      32  data width in bits; must be a multiple of 8 (>= 8)
// - DEPTH      8   number of registers; power of two, >= 2
// - ZERO_REG0  1   1: entry 0 always reads 0 and ignores writes; 0: entry 0 is an ordinary register
// - localparam AW = $clog2(DEPTH), NB = WIDTH/8
// PORTS
// - clk     in   1      rising-edge clock
// - rst     in   1      asynchronous, active-high reset
// - we      in   1      write enable, sampled at posedge clk
// - waddr   in   AW     write address
// - wdata   in   WIDTH  write data
// - wstrb   in   NB     byte-lane strobes; bit i enables wdata[8i+7:8i]
// - raddr0  in   AW     read address, port 0
// - rdata0  out  WIDTH  read data, port 0
// - raddr1  in   AW     read address, port 1
// - rdata1  out  WIDTH  read data, port 1
// BEHAVIOUR
// - Reset: rst=1 clears every entry to 0 immediately, without waiting for clk.
//   - rdata0/rdata1 read 0 while rst is high and after rst is released.
//   - A write that coincides with rst is discarded.
// - Write: at posedge clk with we=1, for each lane i with wstrb[i]=1:
//     mem[waddr][8i+7:8i] <= wdata[8i+7:8i]
//   - Lanes with wstrb[i]=0 keep their old value.
//   - we=1 with wstrb=0 is a legal no-op.
//   - we=0 ignores waddr, wdata and wstrb.
// - Read: combinational, zero latency. rdataN = mem[raddrN].
//   - Without bypass, a write is visible the cycle after its clock edge.
//   - Both ports may address the same entry; both return identical data.
// - ZERO_REG0=1:
//   - Writes to address 0 are dropped.
//   - rdataN is forced to 0 whenever raddrN==0, including under bypass.
// - Address range: all AW-bit addresses are valid because DEPTH is a power of two, so no wrap or error handling is needed.
// - Storage is a flip-flop array, not BRAM, because of the asynchronous reset and combinational reads.
// CONFIGURATION
// - Macro REGFILE_BYPASS_EN:
//   - Defined: write-to-read forwarding. When we=1 and raddrN==waddr (and not the zeroed entry 0):
//     - Each lane with wstrb[i]=1 returns wdata lane i in the same cycle.
//     - Other lanes return the stored value.
//     - Forwarding is suppressed while rst=1.
//   - Undefined: no forwarding; reads return the stored contents only.
//   - Port list is identical in both builds.
// TESTING
// - All runs use WIDTH=32, DEPTH=8, ZERO_REG0=1.
// - Reset: write 0xDEADBEEF to r3, then pulse rst asynchronously mid-cycle.
//   -> rdata0 (raddr0=3) = 0 before the next clk edge.
// - Full write/readback: write r1..r7 = 0x11111111*k with wstrb=4'hF.
//   -> read each on both ports, values match; r0 reads 0.
// - Byte strobe: r2=0xAABBCCDD, then write wdata=0x11223344 with wstrb=4'b0101.
//   -> r2 = 0xAA22CC44.
// - Zero register: write 0xFFFFFFFF to r0 with wstrb=4'hF.
//   -> rdata0 = rdata1 = 0 (bypass build too).
// - Read-during-write on r5 (old value 0x0, new 0x12345678, wstrb=4'hF):
//   - Bypass build -> rdata1 = 0x12345678 in the same cycle.
//   - Plain build -> 0x0, then 0x12345678 after the edge.
// - Write coincident with rst: we=1, waddr=4, rst=1 across the edge.
//   -> r4 = 0 after rst is released.

Source files
------------

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// Parametrised general-purpose register bank: DEPTH words of WIDTH bits with
// one byte-strobed write port and two combinational read ports. Entry 0 can be
// hard-wired to zero (ZERO_REG0=1). Storage is a flip-flop array so that the
// whole bank clears asynchronously and reads have zero latency.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> write-to-read forwarding (same-cycle visibility of the
//                strobed lanes of a write to the addressed entry)
//   undefined -> reads return stored contents only
//
// Parameters
//   WIDTH      data width, multiple of 8 (>= 8)
//   DEPTH      number of entries, power of two (>= 2)
//   ZERO_REG0  1: entry 0 reads 0 and ignores writes
//
// Ports
//   clk     in   1      rising-edge clock
//   rst     in   1      asynchronous active-high reset, clears every entry
//   we      in   1      write enable
//   waddr   in   AW     write address
//   wdata   in   WIDTH  write data
//   wstrb   in   NB     byte-lane strobes (bit i -> wdata[8i+7:8i])
//   raddr0  in   AW     read address, port 0
//   rdata0  out  WIDTH  read data, port 0
//   raddr1  in   AW     read address, port 1
//   rdata1  out  WIDTH  read data, port 1
// -----------------------------------------------------------------------------
module register_file #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int ZERO_REG0 = 1,
  localparam int AW = $clog2(DEPTH),
  localparam int NB = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [NB-1:0]    wstrb,
  input  logic [AW-1:0]    raddr0,
  output logic [WIDTH-1:0] rdata0,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1
);

`ifdef REGFILE_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  localparam logic ZERO0 = (ZERO_REG0 != 0);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] stored0_s;
  logic [WIDTH-1:0] stored1_s;
  logic             fwd_ok_s;

  // Byte-lane merge: strobed lanes take the new data, others keep the old.
  function automatic logic [WIDTH-1:0] merge_lanes(
    input logic [WIDTH-1:0] old_val,
    input logic [WIDTH-1:0] new_val,
    input logic [NB-1:0]    strb
  );
    logic [WIDTH-1:0] res;
    res = old_val;
    for (int i = 0; i < NB; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_val[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_val[8*i +: 8];
      end
    end
    return res;
  endfunction

  // Storage array: async clear, byte-strobed write, entry 0 optionally locked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_r[e] <= {WIDTH{1'b0}};
      end
    end else if (we) begin
      for (int e = 0; e < DEPTH; e++) begin
        if ((waddr == AW'(e)) && !(ZERO0 && (e == 0))) begin
          mem_r[e] <= merge_lanes(mem_r[e], wdata, wstrb);
        end
      end
    end
  end

  assign stored0_s = mem_r[raddr0];
  assign stored1_s = mem_r[raddr1];

  // Forwarding is only possible in the bypass build and never during reset.
  assign fwd_ok_s = BYPASS && we && !rst;

  // Read port 0: zero-register override first, then optional forwarding.
  always_comb begin
    rdata0 = stored0_s;
    if (ZERO0 && (raddr0 == {AW{1'b0}})) begin
      rdata0 = {WIDTH{1'b0}};
    end else if (fwd_ok_s && (raddr0 == waddr)) begin
      rdata0 = merge_lanes(stored0_s, wdata, wstrb);
    end else begin
      rdata0 = stored0_s;
    end
  end

  // Read port 1: identical selection logic to port 0.
  always_comb begin
    rdata1 = stored1_s;
    if (ZERO0 && (raddr1 == {AW{1'b0}})) begin
      rdata1 = {WIDTH{1'b0}};
    end else if (fwd_ok_s && (raddr1 == waddr)) begin
      rdata1 = merge_lanes(stored1_s, wdata, wstrb);
    end else begin
      rdata1 = stored1_s;
    end
  end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [2:0]  raddr0;
  logic [31:0] rdata0;
  logic [2:0]  raddr1;
  logic [31:0] rdata1;

  int checks = 0;
  int errors = 0;

  register_file #(
    .WIDTH    (32),
    .DEPTH    (8),
    .ZERO_REG0(1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .wstrb (wstrb),
    .raddr0(raddr0),
    .rdata0(rdata0),
    .raddr1(raddr1),
    .rdata1(rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive a write on the falling edge, let it commit on the rising edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    wstrb = s;
    @(posedge clk);
    #1;
    we    = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a0, input logic [2:0] a1);
    raddr0 = a0;
    raddr1 = a1;
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    we     = 1'b0;
    waddr  = 3'd0;
    wdata  = 32'h0;
    wstrb  = 4'h0;
    raddr0 = 3'd3;
    raddr1 = 3'd7;

    // Reset state
    #1;
    check("reset_rd0_during_rst", rdata0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_rd0", rdata0, 32'h0);
    check("reset_rd1", rdata1, 32'h0);

    // Async reset mid-cycle clears r3 before the next edge
    wr(3'd3, 32'hDEADBEEF, 4'hF);
    rd(3'd3, 3'd3);
    check("r3_written", rdata0, 32'hDEADBEEF);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_rd0", rdata0, 32'h0);
    check("async_rst_rd1", rdata1, 32'h0);
    #1;
    rst = 1'b0;
    #1;
    check("after_rst_rd0", rdata0, 32'h0);

    // Read-during-write on r5 (old value 0)
    @(negedge clk);
    we     = 1'b1;
    waddr  = 3'd5;
    wdata  = 32'h12345678;
    wstrb  = 4'hF;
    raddr1 = 3'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("rdw_same_cycle", rdata1, 32'h12345678);
`else
    check("rdw_same_cycle", rdata1, 32'h0);
`endif
    @(posedge clk);
    #1;
    we = 1'b0;
    check("rdw_after_edge", rdata1, 32'h12345678);

    // Partial-strobe read-during-write on r5
    @(negedge clk);
    we     = 1'b1;
    waddr  = 3'd5;
    wdata  = 32'hAABBCCDD;
    wstrb  = 4'b0011;
    raddr0 = 3'd5;
    raddr1 = 3'd6;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("rdw_partial", rdata0, 32'h1234CCDD);
`else
    check("rdw_partial", rdata0, 32'h12345678);
`endif
    check("rdw_other_addr", rdata1, 32'h0);
    @(posedge clk);
    #1;
    we = 1'b0;
    check("rdw_partial_stored", rdata0, 32'h1234CCDD);

    // Full write/readback r1..r7 on both ports
    for (int k = 1; k < 8; k++) begin
      wr(3'(k), 32'h11111111 * k, 4'hF);
    end
    for (int k = 1; k < 8; k++) begin
      rd(3'(k), 3'(k));
      check("full_rd0", rdata0, 32'h11111111 * k);
      check("full_rd1", rdata1, 32'h11111111 * k);
    end
    rd(3'd0, 3'd0);
    check("r0_rd0", rdata0, 32'h0);
    check("r0_rd1", rdata1, 32'h0);
    rd(3'd6, 3'd1);
    check("mixed_rd0", rdata0, 32'h66666666);
    check("mixed_rd1", rdata1, 32'h11111111);

    // Byte strobes
    wr(3'd2, 32'hAABBCCDD, 4'hF);
    wr(3'd2, 32'h11223344, 4'b0101);
    rd(3'd2, 3'd2);
    check("strb_0101", rdata0, 32'hAA22CC44);
    wr(3'd2, 32'h99999999, 4'h0);
    rd(3'd2, 3'd3);
    check("strb_none", rdata0, 32'hAA22CC44);
    check("strb_none_neighbour", rdata1, 32'h33333333);
    wr(3'd2, 32'h00EE0000, 4'b1100);
    rd(3'd2, 3'd2);
    check("strb_1100", rdata1, 32'h00EECC44);

    // we=0 ignores the other write inputs
    @(negedge clk);
    we    = 1'b0;
    waddr = 3'd7;
    wdata = 32'h0BADF00D;
    wstrb = 4'hF;
    @(posedge clk);
    #1;
    rd(3'd7, 3'd7);
    check("we_low_ignored", rdata0, 32'h77777777);

    // Zero register, including during the write cycle
    @(negedge clk);
    we     = 1'b1;
    waddr  = 3'd0;
    wdata  = 32'hFFFFFFFF;
    wstrb  = 4'hF;
    raddr0 = 3'd0;
    raddr1 = 3'd0;
    #1;
    check("r0_during_write_rd0", rdata0, 32'h0);
    check("r0_during_write_rd1", rdata1, 32'h0);
    @(posedge clk);
    #1;
    we = 1'b0;
    check("r0_after_write_rd0", rdata0, 32'h0);
    check("r0_after_write_rd1", rdata1, 32'h0);

    // Write coincident with reset is discarded
    @(negedge clk);
    we    = 1'b1;
    waddr = 3'd4;
    wdata = 32'hCAFEF00D;
    wstrb = 4'hF;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    we  = 1'b0;
    rst = 1'b0;
    rd(3'd4, 3'd1);
    check("wr_during_rst_r4", rdata0, 32'h0);
    check("rst_clears_r1", rdata1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
